// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause 22 MDIO management master (single read/write frames)
module mdio_master #(
    parameter int CLK_DIV     = 25,
    parameter bit PREAMBLE_EN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_rd,
    input  logic [4:0]  i_phy_addr,
    input  logic [4:0]  i_reg_addr,
    input  logic [15:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_rdata,
    output logic        o_rd_err,
    output logic        o_mdc,
    output logic        o_mdo,
    output logic        o_mdo_t,
    input  logic        i_mdi
);

    localparam int FRAME_BITS = PREAMBLE_EN ? 64 : 32;
    localparam int PRE_BITS   = PREAMBLE_EN ? 32 : 0;
    localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       LAST_BIT = 6'(FRAME_BITS - 1);
    localparam logic [5:0]       TA1_BIT  = 6'(PRE_BITS + 14);
    localparam logic [5:0]       TA2_BIT  = 6'(PRE_BITS + 15);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shreg;
    logic [DIV_W-1:0]        div;
    logic [5:0]              bit_cnt;
    logic [5:0]              next_bit;
    logic                    rd_lat;
    logic [15:0]             rx_data;
    logic                    rx_err;
    logic [31:0]             frame_body;

    // Read frames carry 1s in the TA/DATA slots; those bits are never driven.
    always_comb begin
        frame_body = {2'b01, (i_rd ? 2'b10 : 2'b01), i_phy_addr, i_reg_addr,
                      (i_rd ? 2'b11 : 2'b10), (i_rd ? 16'hFFFF : i_wdata)};
        next_bit   = bit_cnt + 6'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            div      <= '0;
            bit_cnt  <= '0;
            rd_lat   <= 1'b0;
            rx_data  <= '0;
            rx_err   <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_rdata  <= '0;
            o_rd_err <= 1'b0;
            o_mdc    <= 1'b0;
            o_mdo    <= 1'b1;
            o_mdo_t  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    o_mdc   <= 1'b0;
                    o_mdo_t <= 1'b0;
                    o_mdo   <= 1'b1;
                    if (i_start) begin
                        shreg   <= FRAME_BITS'({32'hFFFF_FFFF, frame_body});
                        o_mdo   <= PREAMBLE_EN ? 1'b1 : frame_body[31];
                        o_mdo_t <= 1'b1;
                        rd_lat  <= i_rd;
                        div     <= '0;
                        bit_cnt <= '0;
                        o_busy  <= 1'b1;
                        state   <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div != DIV_LAST) begin
                        div <= div + DIV_W'(1);
                    end else begin
                        div <= '0;
                        if (!o_mdc) begin
                            // Rising MDC: the PHY's bit is stable here.
                            o_mdc <= 1'b1;
                            if (rd_lat && bit_cnt == TA2_BIT) begin
                                rx_err <= i_mdi;
                            end else if (rd_lat && bit_cnt > TA2_BIT) begin
                                rx_data <= {rx_data[14:0], i_mdi};
                            end
                        end else if (bit_cnt == LAST_BIT) begin
                            o_mdc   <= 1'b0;
                            o_mdo_t <= 1'b0;
                            o_mdo   <= 1'b1;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state   <= DONE;
                            if (rd_lat) begin
                                o_rdata  <= rx_data;
                                o_rd_err <= rx_err;
                            end
                        end else begin
                            // Falling MDC: present the next bit for the whole low phase.
                            o_mdc   <= 1'b0;
                            bit_cnt <= next_bit;
                            shreg   <= {shreg[FRAME_BITS-2:0], 1'b1};
                            o_mdo   <= shreg[FRAME_BITS-2];
                            if (rd_lat && next_bit >= TA1_BIT) begin
                                o_mdo_t <= 1'b0;
                            end
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mdio_master.md
Name: mdio_master

Overview:
- Clause 22 MDIO management master. Serialises single read/write register transactions from a parallel host request.
- Sits directly upstream of the MDIO pad interface stage. Produces the MDC clock, the MDO data bit and the MDO output-enable, and samples the returned MDI bit.
- Host side is a start/busy/done handshake with a latched read-data register.

Parameters:
- CLK_DIV, 25: i_clk cycles per MDC half-period (MDC = f_clk/(2*CLK_DIV)); legal range >= 1.
- PREAMBLE_EN, 1: 1 = send a 32-bit all-ones preamble; 0 = suppress it (frame is 32 bits).

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  reset, asynchronous, active-low
- i_start  input  1  one-cycle request strobe, accepted only when o_busy=0
- i_rd  input  1  1 = read (OP=10), 0 = write (OP=01); latched on accept
- i_phy_addr  input  5  PHYAD, latched on accept
- i_reg_addr  input  5  REGAD, latched on accept
- i_wdata  input  16  write data, latched on accept
- o_busy  output  1  transaction in progress
- o_done  output  1  one-cycle pulse at end of frame
- o_rdata  output  16  last read data; holds until the next read completes
- o_rd_err  output  1  second TA bit sampled as 1 on the last read (no PHY response)
- o_mdc  output  1  MDC to the pad stage
- o_mdo  output  1  serial data to the pad stage
- o_mdo_t  output  1  1 = drive MDIO, 0 = release (high-Z at the pad)
- i_mdi  input  1  sampled MDIO from the pad stage

Behaviour:
- Reset values (asynchronous): o_busy=0, o_done=0, o_rdata=0, o_rd_err=0, o_mdc=0, o_mdo=1, o_mdo_t=0. State=IDLE, divider=0, bit counter=0.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - o_mdc=0, o_mdo_t=0, o_mdo=1.
  - i_start=1 latches all request fields and loads a 64-bit shift register (32-bit when PREAMBLE_EN=0).
  - Next cycle: o_busy=1, state=SHIFT.
- Frame bit order (MSB first): preamble 32x1, ST=01, OP, PHYAD[4:0], REGAD[4:0], TA, DATA[15:0].
  - Write: TA=10, DATA=i_wdata.
  - Read: TA and DATA positions carry 1s internally but are not driven.
- SHIFT, bit timing:
  - Each bit lasts 2*CLK_DIV clocks: CLK_DIV clocks with o_mdc=0, then CLK_DIV clocks with o_mdc=1.
  - o_mdo changes only while o_mdc=0, on the first cycle of the low phase. The first bit is presented on the first SHIFT cycle.
  - The divider counts 0..CLK_DIV-1 and toggles o_mdc on terminal count.
- o_mdo_t:
  - Write: 1 for the whole frame.
  - Read: 1 through REGAD[0]; 0 from the first TA bit to end of frame.
- Read sampling:
  - i_mdi is sampled on the clock where o_mdc goes 0->1, for the second TA bit and for the 16 data bits.
  - Data shifts in MSB first.
  - The second TA bit sampled as 1 sets o_rd_err.
- End of frame:
  - After the high phase of the last bit, o_mdc=0 and o_mdo_t=0; state=DONE.
- DONE (one cycle):
  - o_done=1, o_busy=0 in the same cycle.
  - For reads, o_rdata and o_rd_err update in that cycle.
  - Next cycle returns to IDLE.
- Latency: i_start accept to o_done = 1 + FRAME_BITS*2*CLK_DIV clocks. With CLK_DIV=2: 257 clocks with preamble, 129 without.
- i_start while o_busy=1, or in the DONE cycle: ignored, no effect on the latched fields.
- Write transactions leave o_rdata and o_rd_err unchanged.
- i_rst_n low mid-frame: immediate return to reset values. The partial frame is abandoned with no o_done, and MDIO is released at once.

Test Plan:
- CLK_DIV=2, write PHY=1 REG=0 data=0x1140: decode o_mdo at each o_mdc rising edge -> 32x1, 0101, 00001, 00000, 10, 0001000101000000. o_mdo_t=1 throughout; o_done at clock 257 after accept.
- Read PHY=1 REG=2, PHY model drives TA=0 then 0x796D -> o_rdata=0x796D, o_rd_err=0. o_mdo_t falls at bit 46; no o_mdo change while o_mdc=1.
- Read with i_mdi tied 1 (no PHY) -> o_rdata=0xFFFF, o_rd_err=1, o_done pulses once.
- Pulse i_start with different fields at clock 50 of an active write -> frame bits unchanged, single o_done, o_busy stays 1 until DONE.
- Assert i_rst_n=0 at bit 40 of a read -> same cycle o_mdo_t=0, o_mdc=0, o_busy=0; no o_done; a subsequent write completes normally.
- PREAMBLE_EN=0, CLK_DIV=1, write PHY=31 REG=31 data=0xFFFF -> 32-bit frame starting 01 01 11111 11111 10, o_done 65 clocks after accept.
